mod_74x161_2: RTL



---
 rtl/mod_74x161_2.sv | 86 ++++++++
 1 files changed

// File: rtl/mod_74x161_2.sv
// Cascaded 74x161 synchronous binary counter: CHIPS 4-bit cells chained
// through their ripple-carry outputs into one 4*CHIPS-bit counter.

// Single 74x161 cell: 4-bit counter with async clear, sync load, ENP/ENT count.
module ls161_cell (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_n_i,
    input  logic       enp_i,
    input  logic       ent_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o,
    output logic       rco_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next-state: load beats count, count needs both enables, else hold.
    always_comb begin
        q_d = q_q;
        if (!load_n_i) begin
            q_d = d_i;
        end else if (enp_i && ent_i) begin
            q_d = q_q + 4'd1;
        end
    end

    // Count register; clear acts immediately regardless of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    // Carry is combinational and deliberately independent of ENP.
    assign rco_o = ent_i & (q_q == 4'hF);

endmodule

// Top: chip k>0 takes its ENT from the RCO of chip k-1.
module mod_74x161_2 #(
    parameter int unsigned CHIPS = 2
) (
    input  logic               CLK,
    input  logic               CLR_n,
    input  logic               LOAD_n,
    input  logic               ENP,
    input  logic               ENT,
    input  logic [4*CHIPS-1:0] D,
    output logic [4*CHIPS-1:0] Q,
    output logic               RCO,
    output logic [CHIPS-1:0]   RCO_CHAIN
);

    localparam int unsigned NIB_W = 4;

    logic [CHIPS-1:0] ent_chain;

    // Cell array with the ENT ripple chain.
    for (genvar k = 0; k < CHIPS; k++) begin : g_cell
        if (k == 0) begin : g_first
            assign ent_chain[k] = ENT;
        end else begin : g_rest
            assign ent_chain[k] = RCO_CHAIN[k-1];
        end

        ls161_cell u_cell (
            .clk      (CLK),
            .rst_n    (CLR_n),
            .load_n_i (LOAD_n),
            .enp_i    (ENP),
            .ent_i    (ent_chain[k]),
            .d_i      (D[NIB_W*k +: NIB_W]),
            .q_o      (Q[NIB_W*k +: NIB_W]),
            .rco_o    (RCO_CHAIN[k])
        );
    end

    // Last cell's carry equals ENT AND (Q == all ones) through the chain.
    assign RCO = RCO_CHAIN[CHIPS-1];

endmodule
